// File: rtl/cpu_pkg.sv
// cpu_pkg: shared word width, fetch FSM states and PC step.
// The `WORD range macro is defined here for the whole fetch slice.
`ifndef WORD
`define WORD [31:0]
`endif

package cpu_pkg;

  typedef logic `WORD word_t;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    FLUSH,
    FAULT
  } fetch_state_t;

  localparam word_t PC_INC = 32'd4;

  typedef struct packed {
    word_t pc;
    word_t data;
  } fetch_ent_t;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: imem request/response, instruction and redirect bundle.
// master = fetch unit, slave = memory/controller side.
interface instr_fetch_if;

  logic       imem_req_valid;
  logic       imem_req_ready;
  logic `WORD imem_req_addr;
  logic       imem_rsp_valid;
  logic `WORD imem_rsp_data;
  logic       instr_valid;
  logic       instr_ready;
  logic `WORD instr;
  logic `WORD instr_pc;
  logic       redirect_valid;
  logic `WORD redirect_pc;
  logic       fetch_fault;

  modport master (
    output imem_req_valid, imem_req_addr,
    output instr_valid, instr, instr_pc,
    output fetch_fault,
    input  imem_req_ready, imem_rsp_valid,
    input  imem_rsp_data, instr_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  instr_valid, instr, instr_pc,
    input  fetch_fault,
    output imem_req_ready, imem_rsp_valid,
    output imem_rsp_data, instr_ready,
    output redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_buf.sv
// fetch_buf: DEPTH-entry synchronous FIFO of {pc, instr}.
// clear wins over push/pop; the caller guarantees no overflow.
module fetch_buf
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       push,
  input  fetch_ent_t wdata,
  input  logic       pop,
  output fetch_ent_t rdata,
  output logic       empty,
  output logic [2:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  fetch_ent_t    mem [DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;

  function automatic logic [AW-1:0] bump(
    input logic [AW-1:0] p
  );
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= wdata;
        wr      <= bump(wr);
      end
      if (pop) begin
        rd <= bump(rd);
      end
      count <= count + 3'(push) - 3'(pop);
    end
  end

  assign rdata = mem[rd];
  assign empty = (count == 3'd0);

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: credit-limited fetch with redirect flush of stale responses.
// Define FETCH_MISALIGN_CHECK_EN to fault on misaligned redirect targets.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC  = 32'h0000_0000,
  parameter int    BUF_DEPTH = 2
) (
  input logic           clk,
  input logic           rst_n,
  instr_fetch_if.master bus
);

  fetch_state_t state;
  fetch_state_t state_nxt;
  word_t        pc;
  word_t        ret_pc;
  word_t        tgt;
  logic [2:0]   outst;
  logic [2:0]   kill;
  logic [2:0]   kill_nxt;
  logic [2:0]   count;
  logic         redir;
  logic         bad;
  logic         hs;
  logic         rsp;
  logic         req_v;
  logic         push;
  logic         pop;
  logic         clear;
  logic         empty;
  fetch_ent_t   head;
  fetch_ent_t   wr_ent;

  assign redir = bus.redirect_valid && (state != FAULT);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault;

  assign tgt = bus.redirect_pc;
  assign bad = (bus.redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault <= 1'b0;
    end else if (redir && bad) begin
      fault <= 1'b1;
    end
  end

  assign bus.fetch_fault = fault;
`else
  assign tgt = bus.redirect_pc & ~32'h3;
  assign bad = 1'b0;
  assign bus.fetch_fault = 1'b0;
`endif

  assign hs  = req_v && bus.imem_req_ready;
  assign rsp = bus.imem_rsp_valid;

  // in-flight responses to discard; one of outst/kill is always zero here
  assign kill_nxt = outst + kill + 3'(hs) - 3'(rsp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      redir && bad: state_nxt = FAULT;
      redir && !bad: begin
        state_nxt = (kill_nxt != 3'd0) ? FLUSH : FETCH;
      end
      !redir && state == BOOT: state_nxt = FETCH;
      !redir && state == FLUSH && rsp && kill == 3'd1: begin
        state_nxt = FETCH;
      end
      default: ;
    endcase
  end

  always_comb begin
    req_v = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    clear = 1'b0;
    unique case (state)
      FETCH: begin
        req_v = !bus.redirect_valid
             && (({1'b0, outst} + {1'b0, count})
                 < 4'(BUF_DEPTH));
        push  = rsp && !bus.redirect_valid;
        pop   = !empty && bus.instr_ready
             && !bus.redirect_valid;
        clear = bus.redirect_valid;
      end
      FLUSH: clear = bus.redirect_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      ret_pc <= RESET_PC;
      outst  <= '0;
      kill   <= '0;
    end else if (redir) begin
      pc     <= tgt;
      ret_pc <= tgt;
      outst  <= '0;
      kill   <= kill_nxt;
    end else begin
      if (hs) begin
        pc <= pc + PC_INC;
      end
      if (push) begin
        ret_pc <= ret_pc + PC_INC;
      end
      outst <= outst + 3'(hs) - 3'(push);
      if (state == FLUSH && rsp) begin
        kill <= kill - 3'd1;
      end
    end
  end

  assign wr_ent = '{pc: ret_pc, data: bus.imem_rsp_data};

  fetch_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .wdata (wr_ent),
    .pop   (pop),
    .rdata (head),
    .empty (empty),
    .count (count)
  );

  assign bus.imem_req_valid = req_v;
  assign bus.imem_req_addr  = pc;
  assign bus.instr_valid    = !empty;
  assign bus.instr          = head.data;
  assign bus.instr_pc       = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed fetch scenarios with a queue scoreboard.
// Memory model answers with ~addr one cycle after acceptance.
module tb_instr_fetch;

  typedef struct {
    logic [31:0] a;
    int          due;
  } pend_t;

  logic clk = 1'b0;
  logic rst_n;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int passed   = 0;
  int total    = 0;
  int issued   = 0;
  int consumed = 0;
  int cyc      = 0;
  int cap      = 8;
  bit hold     = 1'b0;

  logic [31:0] exp_req[$];
  logic [31:0] exp_pc[$];
  pend_t       pend[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // memory: accept at negedge sample, answer after the following edge
  always @(negedge clk) begin
    if (rst_n && bus.imem_req_valid && bus.imem_req_ready)
      pend.push_back('{a: bus.imem_req_addr, due: cyc + 1});
  end

  initial begin
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) pend.delete();
      if (rst_n && !hold && pend.size() > 0 && pend[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = ~pend[0].a;
        void'(pend.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
      end
      bus.imem_req_ready = (pend.size() < cap);
    end
  end

  // monitor: checks every request/instruction against the scoreboard
  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (rst_n) begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        issued++;
        if (exp_req.size() > 0) begin
          e = exp_req.pop_front();
          check("req_addr", bus.imem_req_addr, e);
        end
      end
      if (bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
        consumed++;
        if (exp_pc.size() == 0) begin
          total++;
          $display("FAIL instr: unexpected pc %h", bus.instr_pc);
        end else begin
          e = exp_pc.pop_front();
          check("instr_pc", bus.instr_pc, e);
          check("instr", bus.instr, ~e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_pc.size() > 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (exp_pc.size() > 0) begin
      total++;
      $display("FAIL %s: timeout, %0d left", name, exp_pc.size());
      exp_pc.delete();
    end
    #1 bus.instr_ready = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] t);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = t;
    @(posedge clk);
    #1 bus.redirect_valid = 1'b0;
  endtask

  task automatic push_pcs(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_pc.push_back(base + 32'(4 * i));
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
    check({tag, "_req_addr"}, bus.imem_req_addr, 32'd0);
    check({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
    check({tag, "_instr"}, bus.instr, 32'd0);
    check({tag, "_instr_pc"}, bus.instr_pc, 32'd0);
    check({tag, "_fault"}, 32'(bus.fetch_fault), 32'd0);
  endtask

  initial begin
    int n;
    int v;
    int maxv;
    int n0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset_outs("rst");
    repeat (3) @(posedge clk);

    // reset release: 0,4,8 back to back and delivered in order
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    exp_req.push_back(32'h8);
    push_pcs(32'h0, 3);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!(bus.imem_req_valid && bus.imem_req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("first_req_seen", 32'(n < 20), 32'd1);
    @(negedge clk);
    check("b2b_1", 32'(bus.imem_req_valid && bus.imem_req_ready), 32'd1);
    @(negedge clk);
    check("b2b_2", 32'(bus.imem_req_valid && bus.imem_req_ready), 32'd1);
    @(posedge clk);
    #1 drain("boot_stream");

    // controller stall: credit caps in-flight + buffered at depth
    maxv = 0;
    repeat (10) begin
      @(posedge clk);
      #2 v = issued - consumed;
      if (v > maxv) maxv = v;
    end
    check("stall_max_inflight", 32'(maxv), 32'd3);
    check("stall_valid", 32'(bus.instr_valid), 32'd1);
    push_pcs(32'hC, 4);
    #1 bus.instr_ready = 1'b1;
    drain("stall_release");

    // redirect with two responses outstanding
    tick(6);
    hold = 1'b1;
    cap  = 2;
    exp_req.push_back(32'h200);
    exp_req.push_back(32'h204);
    redirect(32'h200);
    n = 0;
    while (pend.size() < 2 && n < 20) begin
      tick(1);
      n++;
    end
    check("two_outstanding", 32'(pend.size()), 32'd2);
    exp_req.push_back(32'h100);
    redirect(32'h100);
    hold = 1'b0;
    cap  = 8;
    push_pcs(32'h100, 2);
    bus.instr_ready = 1'b1;
    drain("stale_drop");

    // pc wrap at the top of the address space
    tick(8);
    check("pre_wrap_full", 32'(bus.instr_valid), 32'd1);
    exp_req.push_back(32'hFFFF_FFF8);
    exp_req.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0000_0000);
    redirect(32'hFFFF_FFF8);
    @(negedge clk);
    check("redir_clears_buf", 32'(bus.instr_valid), 32'd0);
    push_pcs(32'hFFFF_FFF8, 4);
    tick(1);
    bus.instr_ready = 1'b1;
    drain("wrap");

    // reset with a full buffer
    tick(8);
    check("pre_rst_full", 32'(bus.instr_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outs("midrst");
    tick(2);
    exp_req.push_back(32'h0);
    push_pcs(32'h0, 2);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    drain("restart");

    // misaligned redirect target
    tick(8);
`ifdef FETCH_MISALIGN_CHECK_EN
    redirect(32'h102);
    check("fault_set", 32'(bus.fetch_fault), 32'd1);
    check("fault_buf_empty", 32'(bus.instr_valid), 32'd0);
    n0 = issued;
    tick(10);
    check("fault_no_req", 32'(issued - n0), 32'd0);
    check("fault_sticky", 32'(bus.fetch_fault), 32'd1);
`else
    exp_req.push_back(32'h100);
    redirect(32'h102);
    check("no_fault", 32'(bus.fetch_fault), 32'd0);
    push_pcs(32'h100, 2);
    bus.instr_ready = 1'b1;
    drain("misalign_forced");
`endif

    check("exp_req_drained", 32'(exp_req.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
